// File: rtl/hzd_pkg.sv
// Shared types and constants for the D-stage hazard scoreboard:
// forwarding selects, Tuse/Tnew names and the in-flight write record.
package hzd_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2,
        FWD_E  = 2'd3
    } fwd_sel_e;

    localparam logic [1:0] TUSE_0 = 2'd0;
    localparam logic [1:0] TUSE_1 = 2'd1;
    localparam logic [1:0] TUSE_2 = 2'd2;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       md_start;
        logic       md_div;
    } hzd_rec_t;

    localparam hzd_rec_t HZD_BUBBLE = '0;

    // Tnew one stage further down the pipe, never below zero.
    function automatic logic [1:0] tnew_step(input logic [1:0] t);
        return (t == TNEW_0) ? TNEW_0 : t - TNEW_1;
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// HI/LO multiply/divide busy counter: loads the operation latency when a
// multiply or divide leaves E, then counts down to idle.
module md_busy_ctr #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit for the five-stage MIPS pipeline: E/M/W write
// scoreboard with remaining Tnew, stall generation and forwarding selects.
module hazard_scoreboard
    import hzd_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_cal_r,
    input  logic       d_cal_i,
    input  logic       d_lui,
    input  logic       d_load,
    input  logic       d_store,
    input  logic       d_branch,
    input  logic       d_jal,
    input  logic       d_jr,
    input  logic       d_jalr,
    input  logic       d_shift,
    input  logic       d_rt0,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_to,
    input  logic       d_md_from,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_rd,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt,
    output logic       md_busy
);

    hzd_rec_t   e_rec;
    hzd_rec_t   d_rec;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic [4:0] m_rt;
    logic [4:0] w_wa;

    logic       rs_used, rt_used;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] d_wa;
    logic [1:0] d_tnew;
    logic       rs_stall, rt_stall, md_stall;

    // D decode: source timing, destination and result latency.
    always_comb begin
        rs_used = d_branch | d_jr | d_jalr | d_cal_r | d_cal_i | d_load | d_store;
        tuse_rs = (d_branch | d_jr | d_jalr) ? TUSE_0 : TUSE_1;
        rt_used = (d_branch & ~d_rt0) | d_cal_r | d_shift | d_store;
        tuse_rt = d_branch ? TUSE_0 : (d_store ? TUSE_2 : TUSE_1);

        d_wa = REG_ZERO;
        if ((d_cal_r | d_shift | d_jalr) & ~(d_md_start | d_md_to)) begin
            d_wa = d_rd;
        end else if (d_cal_i | d_lui | d_load) begin
            d_wa = d_rt;
        end else if (d_jal) begin
            d_wa = REG_RA;
        end

        d_tnew = TNEW_0;
        if (d_load) begin
            d_tnew = TNEW_2;
        end else if (d_cal_r | d_cal_i | d_lui | d_shift | d_md_from) begin
            d_tnew = TNEW_1;
        end

        d_rec          = HZD_BUBBLE;
        d_rec.wa       = d_wa;
        d_rec.tnew     = d_tnew;
        d_rec.rs       = d_rs;
        d_rec.rt       = d_rt;
        d_rec.md_start = d_md_start;
        d_rec.md_div   = d_md_start & d_md_div;
    end

    // The nearest producer decides: an E hit masks any older M hit.
    function automatic logic src_stall(input logic used, input logic [4:0] src,
                                       input logic [1:0] tuse, input hzd_rec_t e,
                                       input logic [4:0] mwa, input logic [1:0] mtnew);
        logic hit_e, hit_m;
        hit_e = used && (src != REG_ZERO) && (src == e.wa);
        hit_m = used && (src != REG_ZERO) && (src == mwa);
        if (hit_e) return e.tnew > tuse;
        return hit_m && (mtnew > tuse);
    endfunction

    function automatic fwd_sel_e sel_d(input logic [4:0] src, input hzd_rec_t e,
                                       input logic [4:0] mwa, input logic [1:0] mtnew);
        if (src != REG_ZERO && src == e.wa && e.tnew == TNEW_0) return FWD_E;
        if (src != REG_ZERO && src == mwa && mtnew == TNEW_0) return FWD_M;
        return FWD_RF;
    endfunction

    function automatic fwd_sel_e sel_e(input logic [4:0] src, input logic [4:0] mwa,
                                       input logic [1:0] mtnew, input logic [4:0] wwa);
        if (src != REG_ZERO && src == mwa && mtnew == TNEW_0) return FWD_M;
        if (src != REG_ZERO && src == wwa) return FWD_W;
        return FWD_RF;
    endfunction

    always_comb begin
        rs_stall = src_stall(rs_used, d_rs, tuse_rs, e_rec, m_wa, m_tnew);
        rt_stall = src_stall(rt_used, d_rt, tuse_rt, e_rec, m_wa, m_tnew);
        md_stall = (d_md_start | d_md_to | d_md_from) & (md_busy | e_rec.md_start);
        stall    = rs_stall | rt_stall | md_stall;

        fwd_d_rs = sel_d(d_rs, e_rec, m_wa, m_tnew);
        fwd_d_rt = sel_d(d_rt, e_rec, m_wa, m_tnew);
        fwd_e_rs = sel_e(e_rec.rs, m_wa, m_tnew, w_wa);
        fwd_e_rt = sel_e(e_rec.rt, m_wa, m_tnew, w_wa);
        fwd_m_rt = (w_wa != REG_ZERO) && (m_rt == w_wa);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_rec  <= HZD_BUBBLE;
            m_wa   <= '0;
            m_tnew <= '0;
            m_rt   <= '0;
            w_wa   <= '0;
        end else begin
            e_rec  <= stall ? HZD_BUBBLE : d_rec;
            m_wa   <= e_rec.wa;
            m_tnew <= tnew_step(e_rec.tnew);
            m_rt   <= e_rec.rt;
            w_wa   <= m_wa;
        end
    end

    md_busy_ctr #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_ctr (
        .clk  (clk),
        .reset(reset),
        .start(e_rec.md_start),
        .div  (e_rec.md_div),
        .busy (md_busy)
    );

    a_one_class: assert property (@(posedge clk) disable iff (reset)
        $onehot0({d_cal_r, d_cal_i, d_lui, d_load, d_store, d_branch, d_jal, d_jr, d_jalr, d_shift}));

    // A second start is always stalled in D, so a load never lands on a running count.
    a_no_reload: assert property (@(posedge clk) disable iff (reset)
        e_rec.md_start |-> !md_busy);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table plus
// randomized instruction stream against a cycle-history reference model.
module tb_hazard_scoreboard;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_cal_r, d_cal_i, d_lui, d_load, d_store, d_branch, d_jal, d_jr, d_jalr, d_shift;
    logic       d_rt0, d_md_start, d_md_div, d_md_to, d_md_from;
    logic [4:0] d_rs, d_rt, d_rd;
    logic       stall, fwd_m_rt, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset),
        .d_cal_r(d_cal_r), .d_cal_i(d_cal_i), .d_lui(d_lui), .d_load(d_load),
        .d_store(d_store), .d_branch(d_branch), .d_jal(d_jal), .d_jr(d_jr),
        .d_jalr(d_jalr), .d_shift(d_shift), .d_rt0(d_rt0), .d_md_start(d_md_start),
        .d_md_div(d_md_div), .d_md_to(d_md_to), .d_md_from(d_md_from),
        .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
        .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .md_busy(md_busy)
    );

    typedef enum int {K_NOP, K_ADDU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BLEZ,
                      K_JAL, K_JR, K_JALR, K_SLL, K_MULT, K_DIV, K_MTHI, K_MFLO} kind_e;

    typedef struct {
        kind_e      k;
        logic [4:0] rs, rt, rd;
    } instr_t;

    typedef struct {
        bit         rst;
        instr_t     ins;
        bit         st;
        int         fdrs, fdrt, fers, fert;
        bit         fmrt, busy;
    } vec_t;

    // Instruction semantics: cycle after D when each source is needed
    // (-1 = not read), destination (0 = none), result latency from E entry.
    typedef struct {
        int rs_when, rt_when, dest, lat;
        bit md, start, div;
    } sem_t;

    // One instruction as it entered E at a given cycle; ready = cycle its result exists.
    typedef struct {
        int dest, ready, rs, rt;
        bit start, div;
    } slot_t;

    int     errors = 0;
    int     checks = 0;
    vec_t   vq[$];
    slot_t  hist[0:4095];
    int     t;
    int     last_start, last_n;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input bit st, input int fdrs, input int fdrt,
                              input int fers, input int fert, input bit fmrt, input bit busy);
        chk({tag, " stall"},    32'(stall),    int'(st));
        chk({tag, " fwd_d_rs"}, 32'(fwd_d_rs), fdrs);
        chk({tag, " fwd_d_rt"}, 32'(fwd_d_rt), fdrt);
        chk({tag, " fwd_e_rs"}, 32'(fwd_e_rs), fers);
        chk({tag, " fwd_e_rt"}, 32'(fwd_e_rt), fert);
        chk({tag, " fwd_m_rt"}, 32'(fwd_m_rt), int'(fmrt));
        chk({tag, " md_busy"},  32'(md_busy),  int'(busy));
    endtask

    function automatic instr_t mk(input kind_e k, input int rs, input int rt, input int rd);
        instr_t x;
        x.k = k; x.rs = 5'(rs); x.rt = 5'(rt); x.rd = 5'(rd);
        return x;
    endfunction

    task automatic drive(input instr_t x);
        {d_cal_r, d_cal_i, d_lui, d_load, d_store, d_branch, d_jal, d_jr, d_jalr, d_shift} = '0;
        {d_rt0, d_md_start, d_md_div, d_md_to, d_md_from} = '0;
        case (x.k)
            K_ADDU: d_cal_r = 1'b1;
            K_ORI:  d_cal_i = 1'b1;
            K_LUI:  d_lui = 1'b1;
            K_LW:   d_load = 1'b1;
            K_SW:   d_store = 1'b1;
            K_BEQ:  d_branch = 1'b1;
            K_BLEZ: begin d_branch = 1'b1; d_rt0 = 1'b1; end
            K_JAL:  d_jal = 1'b1;
            K_JR:   d_jr = 1'b1;
            K_JALR: d_jalr = 1'b1;
            K_SLL:  d_shift = 1'b1;
            K_MULT: begin d_cal_r = 1'b1; d_md_start = 1'b1; end
            K_DIV:  begin d_cal_r = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1; end
            K_MTHI: begin d_cal_r = 1'b1; d_md_to = 1'b1; end
            K_MFLO: begin d_cal_r = 1'b1; d_md_from = 1'b1; end
            default: ;
        endcase
        d_rs = x.rs; d_rt = x.rt; d_rd = x.rd;
    endtask

    function automatic sem_t sem(input instr_t x);
        sem_t s;
        s = '{rs_when: -1, rt_when: -1, dest: 0, lat: 0, md: 0, start: 0, div: 0};
        case (x.k)
            K_ADDU: begin s.rs_when = 1; s.rt_when = 1; s.dest = x.rd; s.lat = 1; end
            K_ORI:  begin s.rs_when = 1; s.dest = x.rt; s.lat = 1; end
            K_LUI:  begin s.dest = x.rt; s.lat = 1; end
            K_LW:   begin s.rs_when = 1; s.dest = x.rt; s.lat = 2; end
            K_SW:   begin s.rs_when = 1; s.rt_when = 2; end
            K_BEQ:  begin s.rs_when = 0; s.rt_when = 0; end
            K_BLEZ: s.rs_when = 0;
            K_JAL:  s.dest = 31;
            K_JR:   s.rs_when = 0;
            K_JALR: begin s.rs_when = 0; s.dest = x.rd; end
            K_SLL:  begin s.rt_when = 1; s.dest = x.rd; s.lat = 1; end
            K_MULT: begin s.rs_when = 1; s.rt_when = 1; s.md = 1; s.start = 1; end
            K_DIV:  begin s.rs_when = 1; s.rt_when = 1; s.md = 1; s.start = 1; s.div = 1; end
            K_MTHI: begin s.rs_when = 1; s.rt_when = 1; s.md = 1; end
            K_MFLO: begin s.rs_when = 1; s.rt_when = 1; s.dest = x.rd; s.lat = 1; s.md = 1; end
            default: ;
        endcase
        return s;
    endfunction

    function automatic slot_t empty_slot();
        return '{dest: 0, ready: 0, rs: 0, rt: 0, start: 0, div: 0};
    endfunction

    task automatic model_reset();
        t = 2;
        for (int i = 0; i <= 2; i++) hist[i] = empty_slot();
        last_start = -1000;
        last_n = 0;
    endtask

    function automatic bit m_busy();
        return (t - last_start >= 1) && (t - last_start <= last_n);
    endfunction

    function automatic bit m_src_stall(input int s, input int when);
        if (when < 0 || s == 0) return 0;
        if (hist[t].dest == s)   return hist[t].ready > t + when;
        if (hist[t-1].dest == s) return hist[t-1].ready > t + when;
        return 0;
    endfunction

    function automatic int m_fwd_d(input int s);
        if (s == 0) return 0;
        if (hist[t].dest == s && hist[t].ready <= t) return 3;
        if (hist[t-1].dest == s && hist[t-1].ready <= t) return 1;
        return 0;
    endfunction

    function automatic int m_fwd_e(input int s);
        if (s == 0) return 0;
        if (hist[t-1].dest == s && hist[t-1].ready <= t) return 1;
        if (hist[t-2].dest == s) return 2;
        return 0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic add(input bit r, input kind_e k, input int rs, input int rt, input int rd,
                       input bit st, input int fdrs, input int fdrt, input int fers,
                       input int fert, input bit fmrt, input bit busy);
        vec_t v;
        v.rst = r; v.ins = mk(k, rs, rt, rd);
        v.st = st; v.fdrs = fdrs; v.fdrt = fdrt; v.fers = fers; v.fert = fert;
        v.fmrt = fmrt; v.busy = busy;
        vq.push_back(v);
    endtask

    function automatic logic [4:0] rand_reg();
        int r;
        r = $urandom_range(0, 7);
        if (r == 6) return 5'd31;
        if (r == 7) return 5'($urandom_range(0, 31));
        return 5'(r);
    endfunction

    function automatic instr_t rand_instr();
        return mk(kind_e'($urandom_range(0, 15)), rand_reg(), rand_reg(), rand_reg());
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        instr_t cur;
        sem_t   s;
        slot_t  sl;
        bit     e_st;

        reset = 1'b1;
        drive(mk(K_MFLO, 31, 0, 3));
        #3;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // lw then dependent addu: one bubble, then W forwards into E
        add(1, K_LW,   1,  8,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_ADDU, 8, 10,  9, 1, 0, 0, 0, 0, 0, 0);
        add(0, K_ADDU, 8, 10,  9, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_NOP,  0,  0,  0, 0, 0, 0, 2, 0, 0, 0);
        // addu then beq
        add(1, K_ADDU, 1,  2,  8, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_BEQ,  8,  0,  0, 1, 0, 0, 0, 0, 0, 0);
        add(0, K_BEQ,  8,  0,  0, 0, 1, 0, 0, 0, 0, 0);
        add(0, K_NOP,  0,  0,  0, 0, 0, 0, 2, 0, 0, 0);
        // lw then beq
        add(1, K_LW,   1,  8,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_BEQ,  8,  9,  0, 1, 0, 0, 0, 0, 0, 0);
        add(0, K_BEQ,  8,  9,  0, 1, 0, 0, 0, 0, 0, 0);
        add(0, K_BEQ,  8,  9,  0, 0, 0, 0, 0, 0, 0, 0);
        // jal in E feeds beq $31 in D
        add(1, K_JAL,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_BEQ, 31,  0,  0, 0, 3, 0, 0, 0, 0, 0);
        add(0, K_NOP,  0,  0,  0, 0, 0, 0, 1, 0, 0, 0);
        // mult, gap, mflo waits out the busy window
        add(1, K_MULT, 1,  2,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_NOP,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MULT_N; i++) add(0, K_MFLO, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1);
        add(0, K_MFLO, 0,  0,  3, 0, 0, 0, 0, 0, 0, 0);
        // div immediately followed by mflo
        add(1, K_DIV,  1,  2,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_MFLO, 0,  0,  3, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DIV_N; i++) add(0, K_MFLO, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1);
        add(0, K_MFLO, 0,  0,  3, 0, 0, 0, 0, 0, 0, 0);
        // writes to $0 never create a hazard
        add(1, K_ORI,  1,  0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_ADDU, 0,  0,  5, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_NOP,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0);
        // E hit (jal, ready) masks M hit (lw, not ready) on $31
        add(1, K_LW,   1, 31,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_JAL,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_JR,  31,  0,  0, 0, 3, 0, 0, 0, 0, 0);
        // store data forwarded from W into M
        add(1, K_LW,   1,  8,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_SW,   2,  8,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_NOP,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_NOP,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0);
        // md stall and data stall together
        add(1, K_MULT, 1,  2,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_LW,   0,  4,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, K_MTHI, 4,  0,  0, 1, 0, 0, 0, 0, 0, 1);

        foreach (vq[i]) begin
            if (vq[i].rst) do_reset();
            drive(vq[i].ins);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vq[i].st, vq[i].fdrs, vq[i].fdrt,
                       vq[i].fers, vq[i].fert, vq[i].fmrt, vq[i].busy);
            @(posedge clk); #1;
        end

        // asynchronous reset while a divide counts at 7
        do_reset();
        drive(mk(K_DIV, 1, 2, 0));
        @(posedge clk); #1;
        drive(mk(K_NOP, 0, 0, 0));
        repeat (3) begin @(posedge clk); #1; end
        drive(mk(K_JAL, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(K_MFLO, 31, 0, 3));
        @(negedge clk);
        check_outs("pre_rst", 1, 3, 0, 0, 0, 0, 1);
        #2 reset = 1'b1;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_outs("post_rst", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // randomized stream against the history model
        do_reset();
        model_reset();
        cur = rand_instr();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                model_reset();
            end
            drive(cur);
            s = sem(cur);
            e_st = m_src_stall(cur.rs, s.rs_when) || m_src_stall(cur.rt, s.rt_when) ||
                   (s.md && (m_busy() || hist[t].start));
            @(negedge clk);
            check_outs($sformatf("rnd%0d", n), e_st, m_fwd_d(cur.rs), m_fwd_d(cur.rt),
                       m_fwd_e(hist[t].rs), m_fwd_e(hist[t].rt),
                       (hist[t-2].dest != 0) && (hist[t-1].rt == hist[t-2].dest), m_busy());
            @(posedge clk); #1;
            if (e_st) begin
                sl = empty_slot();
            end else begin
                sl = '{dest: s.dest, ready: t + 1 + s.lat, rs: cur.rs, rt: cur.rt,
                       start: s.start, div: s.div};
                if (s.start) begin
                    last_start = t + 1;
                    last_n = s.div ? DIV_N : MULT_N;
                end
            end
            hist[t+1] = sl;
            t++;
            if (!(e_st && $urandom_range(0, 9) != 0)) cur = rand_instr();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
